// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-port bundle for the I/D memory port arbiter.
// The slave side is the arbiter; the master side is the core plus RAM.
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BYTES         = 4,
    parameter int DATA_WIDTH    = 8 * BYTES,
    parameter int CNT_WIDTH     = 16
);
    logic                     i_req_valid;
    logic [ADDRESS_WIDTH-1:0] i_req_addr;
    logic                     i_req_ready;
    logic                     i_rsp_valid;
    logic [DATA_WIDTH-1:0]    i_rsp_data;

    logic                     d_req_valid;
    logic                     d_req_we;
    logic [ADDRESS_WIDTH-1:0] d_req_addr;
    logic [BYTES-1:0]         d_req_be;
    logic [DATA_WIDTH-1:0]    d_req_wdata;
    logic                     d_req_ready;
    logic                     d_rsp_valid;
    logic [DATA_WIDTH-1:0]    d_rsp_data;

    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [BYTES-1:0]         mem_be;
    logic [DATA_WIDTH-1:0]    mem_data_in;
    logic                     mem_we;
    logic [DATA_WIDTH-1:0]    mem_data_out;

    logic [CNT_WIDTH-1:0]     conflict_count;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_we, d_req_addr, d_req_be, d_req_wdata,
        input  mem_data_out,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_addr, mem_be, mem_data_in, mem_we,
        output conflict_count
    );

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_we, d_req_addr, d_req_be, d_req_wdata,
        output mem_data_out,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_addr, mem_be, mem_data_in, mem_we,
        input  conflict_count
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read block RAM port between fetch (I) and load/store (D).
// D wins conflicts until it has taken MAX_DATA_STREAK grants in a row.
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int BYTES           = 4,
    parameter int DATA_WIDTH      = 8 * BYTES,
    parameter int MAX_DATA_STREAK = 2,
    parameter int CNT_WIDTH       = 16
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_e;

    owner_e               owner_q, owner_d;
    logic [3:0]           streak_q, streak_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                     grant_i;
    logic                     grant_d;
    logic                     both;
    logic [ADDRESS_WIDTH-1:0] mem_addr_c;
    logic [BYTES-1:0]         mem_be_c;
    logic [DATA_WIDTH-1:0]    mem_data_in_c;
    logic                     mem_we_c;

    // No grant while reset is high, so nothing is left without a response.
    always_comb begin
        both    = bus.i_req_valid && bus.d_req_valid;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (bus.d_req_valid &&
                (!bus.i_req_valid || streak_q != STREAK_MAX))
                grant_d = 1'b1;
            else
                grant_i = bus.i_req_valid;
        end
    end

    always_comb begin
        owner_d  = OWN_NONE;
        streak_d = streak_q;
        cnt_d    = cnt_q;
        unique case (1'b1)
            grant_i: owner_d = OWN_I;
            grant_d: owner_d = OWN_D;
            default: owner_d = OWN_NONE;
        endcase
        if (!bus.i_req_valid || grant_i)
            streak_d = 4'd0;
        else if (grant_d)
            streak_d = streak_q + 4'd1;
        if (both && cnt_q != '1)
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_comb begin
        mem_addr_c    = '0;
        mem_be_c      = '0;
        mem_data_in_c = '0;
        mem_we_c      = 1'b0;
        unique case (1'b1)
            grant_i: mem_addr_c = bus.i_req_addr;
            grant_d: begin
                mem_addr_c    = bus.d_req_addr;
                mem_we_c      = bus.d_req_we;
                mem_be_c      = bus.d_req_we ? bus.d_req_be : '0;
                mem_data_in_c = bus.d_req_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            streak_q <= 4'd0;
            cnt_q    <= '0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.i_req_ready    = grant_i;
    assign bus.d_req_ready    = grant_d;
    assign bus.mem_addr       = mem_addr_c;
    assign bus.mem_be         = mem_be_c;
    assign bus.mem_data_in    = mem_data_in_c;
    assign bus.mem_we         = mem_we_c;
    assign bus.conflict_count = cnt_q;

    // A reset in the response cycle drops the pending response.
    assign bus.i_rsp_valid = !reset && owner_q == OWN_I;
    assign bus.d_rsp_valid = !reset && owner_q == OWN_D;
    assign bus.i_rsp_data  = bus.mem_data_out;
    assign bus.d_rsp_data  = bus.mem_data_out;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level model,
// a byte-enabled registered-read RAM and a CNT_WIDTH=4 saturation instance.
module tb_mem_port_arbiter;
    localparam int MAXS = 2;

    logic clk;
    logic reset;
    logic ram_load;

    mem_port_arbiter_if #(.CNT_WIDTH(16)) bus ();
    mem_port_arbiter_if #(.CNT_WIDTH(4))  bus4 ();

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .CNT_WIDTH(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .CNT_WIDTH(4)) dut4 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus4.slave)
    );

    assign bus4.mem_data_out = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram    [64];
    logic [31:0] shadow [64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int k);
        case (k)
            4:       return 32'h0050_0093;
            5:       return 32'h0010_8113;
            8:       return 32'h1122_3344;
            9:       return 32'hCAFE_F00D;
            default: return 32'h1000_0000 + 32'(k) * 32'h0001_0001;
        endcase
    endfunction

    // RAM: registered read, byte-enabled write, read-during-write gives old data
    always @(posedge clk) begin
        if (ram_load) begin
            for (int k = 0; k < 64; k++) ram[k] <= init_word(k);
        end else begin
            bus.mem_data_out <= ram[bus.mem_addr[7:2]];
            if (bus.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b])
                        ram[bus.mem_addr[7:2]][8*b+:8] <= bus.mem_data_in[8*b+:8];
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: grants from the arbitration rules, responses one
    // cycle later from a shadow memory image.
    int          m_who;
    logic [31:0] m_data;
    logic        m_load;
    int          m_waits;
    int          m_conf;
    bit          seen_rst = 0;
    bit          eg_i, eg_d;
    logic [5:0]  widx;

    initial begin : model
        forever begin
            @(negedge clk);
            if (reset) begin
                if (!seen_rst)
                    for (int k = 0; k < 64; k++) shadow[k] = init_word(k);
                seen_rst = 1;
                check("rst_i_ready", bus.i_req_ready, 0);
                check("rst_d_ready", bus.d_req_ready, 0);
                check("rst_i_rsp", bus.i_rsp_valid, 0);
                check("rst_d_rsp", bus.d_rsp_valid, 0);
                check("rst_mem_we", bus.mem_we, 0);
                m_who   = 0;
                m_waits = 0;
                m_conf  = 0;
            end else if (seen_rst) begin
                eg_d = bus.d_req_valid && (!bus.i_req_valid || m_waits < MAXS);
                eg_i = bus.i_req_valid && !eg_d;
                check("i_ready", bus.i_req_ready, eg_i);
                check("d_ready", bus.d_req_ready, eg_d);
                check("mem_addr", bus.mem_addr,
                      eg_i ? bus.i_req_addr : eg_d ? bus.d_req_addr : 0);
                check("mem_we", bus.mem_we, eg_d && bus.d_req_we);
                check("mem_be", bus.mem_be,
                      (eg_d && bus.d_req_we) ? bus.d_req_be : 4'h0);
                check("mem_data_in", bus.mem_data_in,
                      eg_d ? bus.d_req_wdata : 0);
                check("i_rsp_valid", bus.i_rsp_valid, m_who == 1);
                check("d_rsp_valid", bus.d_rsp_valid, m_who == 2);
                if (m_who == 1) check("i_rsp_data", bus.i_rsp_data, m_data);
                if (m_who == 2 && m_load)
                    check("d_rsp_data", bus.d_rsp_data, m_data);
                check("conflict", bus.conflict_count, m_conf);

                if (bus.i_req_valid && bus.d_req_valid && m_conf < 65535)
                    m_conf++;
                if (!bus.i_req_valid || eg_i) m_waits = 0;
                else if (eg_d) m_waits++;
                m_who  = eg_i ? 1 : eg_d ? 2 : 0;
                widx   = eg_i ? bus.i_req_addr[7:2] : bus.d_req_addr[7:2];
                m_data = shadow[widx];
                m_load = !(eg_d && bus.d_req_we);
                if (eg_d && bus.d_req_we)
                    for (int b = 0; b < 4; b++)
                        if (bus.d_req_be[b])
                            shadow[widx][8*b+:8] = bus.d_req_wdata[8*b+:8];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        bus.i_req_valid = 0;
        bus.d_req_valid = 0;
        bus.d_req_we    = 0;
    endtask

    string      seq;
    logic [7:0] got;

    initial begin
        reset = 1;
        ram_load = 1;
        bus.i_req_addr  = '0;
        bus.d_req_addr  = '0;
        bus.d_req_be    = '0;
        bus.d_req_wdata = '0;
        idle_all();
        bus4.i_req_valid = 0;
        bus4.i_req_addr  = '0;
        bus4.d_req_valid = 0;
        bus4.d_req_we    = 0;
        bus4.d_req_addr  = '0;
        bus4.d_req_be    = '0;
        bus4.d_req_wdata = '0;
        cyc();
        ram_load = 0;
        cyc();
        reset = 0;

        // reset then idle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_ready", {bus.i_req_ready, bus.d_req_ready}, 0);
            check("idle_rsp", {bus.i_rsp_valid, bus.d_rsp_valid}, 0);
            check("idle_conf", bus.conflict_count, 0);
            cyc();
        end

        // lone fetch
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h10;
        @(negedge clk);
        check("fetch_ready", bus.i_req_ready, 1);
        cyc();
        idle_all();
        @(negedge clk);
        check("fetch_rsp", {bus.i_rsp_valid, bus.d_rsp_valid}, 2'b10);
        check("fetch_data", bus.i_rsp_data, 32'h0050_0093);
        cyc();

        // store then load
        bus.d_req_valid = 1;
        bus.d_req_we    = 1;
        bus.d_req_addr  = 32'h20;
        bus.d_req_be    = 4'b0011;
        bus.d_req_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        check("st_we", bus.mem_we, 1);
        cyc();
        bus.d_req_we = 0;
        @(negedge clk);
        check("st_ack", bus.d_rsp_valid, 1);
        cyc();
        idle_all();
        @(negedge clk);
        check("ld_valid", bus.d_rsp_valid, 1);
        check("ld_data", bus.d_rsp_data, 32'h1122_CCDD);
        cyc();

        // back-to-back mixed
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h10;
        cyc();
        bus.i_req_valid = 0;
        bus.d_req_valid = 1;
        bus.d_req_addr  = 32'h24;
        @(negedge clk);
        check("mix1_rsp", {bus.i_rsp_valid, bus.d_rsp_valid}, 2'b10);
        check("mix1_data", bus.i_rsp_data, 32'h0050_0093);
        cyc();
        bus.d_req_valid = 0;
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h14;
        @(negedge clk);
        check("mix2_rsp", {bus.i_rsp_valid, bus.d_rsp_valid}, 2'b01);
        check("mix2_data", bus.d_rsp_data, 32'hCAFE_F00D);
        cyc();
        idle_all();
        @(negedge clk);
        check("mix3_rsp", {bus.i_rsp_valid, bus.d_rsp_valid}, 2'b10);
        check("mix3_data", bus.i_rsp_data, 32'h0010_8113);
        cyc();

        // starvation limit, counted from a fresh reset
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        seq = "DDIDDI";
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h10;
        bus.d_req_valid = 1;
        bus.d_req_we    = 0;
        bus.d_req_addr  = 32'h20;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            got = bus.d_req_ready ? 8'h44 : bus.i_req_ready ? 8'h49 : 8'h2D;
            check($sformatf("grant%0d", k), got, seq[k]);
            cyc();
        end
        idle_all();
        @(negedge clk);
        check("starve_conf", bus.conflict_count, 6);
        cyc();
        cyc();

        // reset mid-flight
        bus.i_req_valid = 1;
        bus.i_req_addr  = 32'h10;
        @(negedge clk);
        check("mid_ready", bus.i_req_ready, 1);
        cyc();
        idle_all();
        reset = 1;
        @(negedge clk);
        check("mid_rsp1", bus.i_rsp_valid, 0);
        cyc();
        reset = 0;
        @(negedge clk);
        check("mid_rsp2", bus.i_rsp_valid, 0);
        cyc();

        // 4-bit conflict counter saturation
        bus4.i_req_valid = 1;
        bus4.d_req_valid = 1;
        for (int k = 0; k < 14; k++) cyc();
        @(negedge clk);
        check("sat14", bus4.conflict_count, 14);
        for (int k = 0; k < 6; k++) cyc();
        @(negedge clk);
        check("sat20", bus4.conflict_count, 15);
        bus4.i_req_valid = 0;
        bus4.d_req_valid = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single read/write port of the program/data block RAM between two requesters: instruction fetch (I) and load/store (D).
- Sits between the core and the RAM and drives the RAM port directly.
- RAM is word-addressed internally by addr[31:2] and has a byte-enabled write; read data is registered, so it appears one cycle after the address.
- The arbiter grants at most one request per cycle and routes the registered read data back to the requester that owned the access.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- BYTES, 4, byte lanes per word.
- DATA_WIDTH, 32, word width (8*BYTES).
- MAX_DATA_STREAK, 2, maximum consecutive D grants while I is waiting; range 1..15.
- CNT_WIDTH, 16, width of the conflict counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  fetch request
- i_req_addr  in  ADDRESS_WIDTH  fetch byte address
- i_req_ready  out  1  fetch request accepted this cycle
- i_rsp_valid  out  1  fetch data valid
- i_rsp_data  out  DATA_WIDTH  fetch word
- d_req_valid  in  1  load/store request
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDRESS_WIDTH  load/store byte address
- d_req_be  in  BYTES  store byte enables
- d_req_wdata  in  DATA_WIDTH  store data
- d_req_ready  out  1  D request accepted this cycle
- d_rsp_valid  out  1  D completion (load data or store ack)
- d_rsp_data  out  DATA_WIDTH  load word; undefined for stores
- mem_addr  out  ADDRESS_WIDTH  RAM byte address
- mem_be  out  BYTES  RAM byte enables
- mem_data_in  out  DATA_WIDTH  RAM write data
- mem_we  out  1  RAM write enable
- mem_data_out  in  DATA_WIDTH  RAM registered read data
- conflict_count  out  CNT_WIDTH  cycles with both requests pending

Behaviour:
- Reset: owner register = NONE, streak = 0, conflict_count = 0, i_rsp_valid = d_rsp_valid = 0.
  - Combinational outputs with no valid input: readys = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_data_in = 0.
- Handshake:
  - An accept is valid && ready in the same cycle; ready is combinational from the valids and arbiter state.
  - Requesters hold valid and all request fields stable until accepted.
  - A requester may issue back-to-back requests; one accept per cycle in total.
- Grant rules, evaluated each cycle:
  - Only one valid: grant it.
  - Both valid: grant D, unless streak == MAX_DATA_STREAK, in which case grant I.
  - Neither valid: no grant.
- Streak counter:
  - +1 on each D grant while i_req_valid = 1.
  - Cleared on any I grant, and in any cycle with i_req_valid = 0.
  - Never exceeds MAX_DATA_STREAK.
- RAM drive, combinational from the granted request:
  - I grant: mem_addr = i_req_addr, mem_we = 0, mem_be = 0.
  - D grant: mem_addr = d_req_addr, mem_we = d_req_we, mem_be = d_req_we ? d_req_be : 0, mem_data_in = d_req_wdata.
  - A store with d_req_be = 0 is still accepted and acknowledged; no byte is written.
- Response pipeline:
  - Owner register loads I, D or NONE at each clock edge according to the grant.
  - In the following cycle: owner I → i_rsp_valid = 1, i_rsp_data = mem_data_out; owner D → d_rsp_valid = 1, d_rsp_data = mem_data_out.
  - Latency from accept to response is exactly 1 cycle.
  - There is no response backpressure; requesters must take the response in that cycle.
  - Full throughput: one access per cycle, with responses overlapping new accepts.
- Data routing:
  - i_rsp_data and d_rsp_data both carry mem_data_out continuously; only the valid bits qualify them.
  - Store response data is the old word content (RAM read-during-write returns old data); requesters ignore it.
- conflict_count: +1 on each cycle with i_req_valid && d_req_valid; saturates at all-ones.
- Reset mid-operation:
  - Reset asserted in the cycle after an accept forces owner = NONE.
  - No response is issued for that accept; a write already performed by the RAM stands.
- Address handling:
  - Addresses pass through unmodified; the low 2 bits are ignored by the RAM.
  - Misalignment checking is not this block's job.

Test Plan:
- Reset then idle: reset 2 cycles, no valids for 3 cycles → all readys/rsp_valids 0, mem_we 0, conflict_count 0.
- Lone fetch: i_req_valid=1, i_req_addr=0x10, RAM word 4 = 0x00500093 → i_req_ready=1 same cycle; next cycle i_rsp_valid=1, i_rsp_data=0x00500093, d_rsp_valid=0.
- Store then load, D only:
  - Cycle 0: store addr 0x20, be=4'b0011, wdata=0xAABBCCDD over word 0x11223344 → mem_we=1, d_rsp_valid=1 at cycle 1.
  - Cycle 1: load addr 0x20 → d_rsp_data=0x1122CCDD at cycle 2.
- Starvation limit: both valid continuously, MAX_DATA_STREAK=2 → grant sequence D,D,I,D,D,I; conflict_count=6 after 6 cycles.
- Back-to-back mixed: I at cycle 0, D load at cycle 1, I at cycle 2 → rsp_valid pulses at cycles 1(I), 2(D), 3(I) with the matching words; never both rsp_valids together.
- Reset mid-flight: fetch accepted at cycle 0, reset at cycle 1 → i_rsp_valid stays 0 at cycles 1 and 2; saturation test with CNT_WIDTH=4 and both valid 20 cycles → conflict_count=15.
